// File: rtl/timer_pkg.sv
// Shared widths, default moduli and terminal digit values for the timer chain.
// Imported by the BCD digit counters and the mod-60 stage.
package timer_pkg;

   localparam int UNITS_W = 4;
   localparam int TENS_W = 3;

   localparam int UNITS_MOD_DEF = 10;
   localparam int TENS_MOD_DEF = 6;

   localparam int UNITS_LAST = 9;
   localparam int TENS_LAST = 5;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single modulo-MOD digit with clear > load > enable > hold priority.
// Ports: clk, rst_n, en, clr, ld, ld_val[W] in; q[W], wrap out (wrap = en && q==MOD-1).
module bcd_digit_counter
   import timer_pkg::*;
#(
   parameter int MOD = UNITS_MOD_DEF,
   parameter int W = UNITS_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   output logic [W-1:0] q,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);
   localparam logic [W-1:0] MODV = W'(MOD);

   logic at_last;
   logic [W-1:0] ld_safe;

   assign at_last = (q == LAST);
   assign wrap = en && at_last;

   // Out-of-range loads collapse to zero so q never leaves 0..MOD-1.
   assign ld_safe = (ld_val < MODV) ? ld_val : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (ld) begin
         q <= ld_safe;
      end else if (en) begin
         q <= at_last ? '0 : q + 1'b1;
      end
   end

endmodule

// File: rtl/mod60_bcd_counter.sv
// Two-digit BCD modulo-60 counter (00..59) with ripple carry for the timer chain.
// Ports: clk, rst_n, en, clr in; units[4], tens[3], tc, carry_out out.
// With BCD60_LOAD_EN defined, adds ld, ld_units[4], ld_tens[3] parallel load inputs.
module mod60_bcd_counter
   import timer_pkg::*;
#(
   parameter int UNITS_MOD = UNITS_MOD_DEF,
   parameter int TENS_MOD = TENS_MOD_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
`ifdef BCD60_LOAD_EN
   input  logic              ld,
   input  logic [UNITS_W-1:0] ld_units,
   input  logic [TENS_W-1:0] ld_tens,
`endif
   output logic [UNITS_W-1:0] units,
   output logic [TENS_W-1:0] tens,
   output logic              tc,
   output logic              carry_out
);

   localparam logic [UNITS_W-1:0] U_LAST = UNITS_W'(UNITS_MOD - 1);
   localparam logic [TENS_W-1:0] T_LAST = TENS_W'(TENS_MOD - 1);

   logic              ld_i;
   logic [UNITS_W-1:0] ld_u_i;
   logic [TENS_W-1:0] ld_t_i;
   logic              units_wrap;
   logic              tens_wrap;

`ifdef BCD60_LOAD_EN
   assign ld_i = ld;
   assign ld_u_i = ld_units;
   assign ld_t_i = ld_tens;
`else
   assign ld_i = 1'b0;
   assign ld_u_i = '0;
   assign ld_t_i = '0;
`endif

   bcd_digit_counter #(
      .MOD(UNITS_MOD),
      .W  (UNITS_W)
   ) u_units (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (clr),
      .ld    (ld_i),
      .ld_val(ld_u_i),
      .q     (units),
      .wrap  (units_wrap)
   );

   // Tens steps only on the units 9->0 edge.
   bcd_digit_counter #(
      .MOD(TENS_MOD),
      .W  (TENS_W)
   ) u_tens (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (units_wrap),
      .clr   (clr),
      .ld    (ld_i),
      .ld_val(ld_t_i),
      .q     (tens),
      .wrap  (tens_wrap)
   );

   assign tc = (units == U_LAST) && (tens == T_LAST);
   assign carry_out = en && tc;

   logic unused_ok;
   assign unused_ok = tens_wrap;

endmodule

// File: tb/tb_mod60_bcd_counter.sv
// Directed self-checking bench for mod60_bcd_counter.
// Load scenarios run only when BCD60_LOAD_EN is defined.
module tb_mod60_bcd_counter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic       ld;
   logic [3:0] ld_units;
   logic [2:0] ld_tens;
   logic [3:0] units;
   logic [2:0] tens;
   logic       tc;
   logic       carry_out;

   int vecs;
   int errs;

   mod60_bcd_counter dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
`ifdef BCD60_LOAD_EN
      .ld       (ld),
      .ld_units (ld_units),
      .ld_tens  (ld_tens),
`endif
      .units    (units),
      .tens     (tens),
      .tc       (tc),
      .carry_out(carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_en(input int n);
      en = 1'b1;
      for (int i = 0; i < n; i++) step();
      en = 1'b0;
   endtask

   task automatic clear_now();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b1;
      step();
      step();
      vecs++;
      if (units !== 4'd0) begin
         errs++;
         $display("FAIL reset_units got %0d want 0", units);
      end
      vecs++;
      if (tens !== 3'd0) begin
         errs++;
         $display("FAIL reset_tens got %0d want 0", tens);
      end
      vecs++;
      if (tc !== 1'b0) begin
         errs++;
         $display("FAIL reset_tc got %b want 0", tc);
      end
      vecs++;
      if (carry_out !== 1'b0) begin
         errs++;
         $display("FAIL reset_carry got %b want 0", carry_out);
      end
      en = 1'b0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_free_run();
      int pulses;
      int last_pulse;
      int gap;
      pulses = 0;
      last_pulse = -1;
      gap = 0;
      clear_now();
      en = 1'b1;
      for (int i = 0; i < 120; i++) begin
         int c;
         c = i % 60;
         vecs++;
         if (units !== 4'(c % 10) || tens !== 3'(c / 10)) begin
            errs++;
            $display("FAIL free_count cyc %0d got %0d%0d want %0d", i, tens, units, c);
         end
         vecs++;
         if (carry_out !== (c == 59) || tc !== (c == 59)) begin
            errs++;
            $display("FAIL free_carry cyc %0d got tc=%b co=%b want %b", i, tc, carry_out, c == 59);
         end
         vecs++;
         if (units > 4'd9 || tens > 3'd5) begin
            errs++;
            $display("FAIL free_range cyc %0d got %0d%0d want <=59", i, tens, units);
         end
         if (carry_out === 1'b1) begin
            if (last_pulse >= 0) gap = i - last_pulse;
            last_pulse = i;
            pulses++;
         end
         step();
      end
      en = 1'b0;
      vecs++;
      if (pulses != 2 || gap != 60) begin
         errs++;
         $display("FAIL free_pulses got %0d gap %0d want 2 gap 60", pulses, gap);
      end
      vecs++;
      if (units !== 4'd0 || tens !== 3'd0) begin
         errs++;
         $display("FAIL free_wrap got %0d%0d want 00", tens, units);
      end
   endtask

   task automatic test_async_reset();
      clear_now();
      run_en(37);
      vecs++;
      if (units !== 4'd7 || tens !== 3'd3) begin
         errs++;
         $display("FAIL pre_reset got %0d%0d want 37", tens, units);
      end
      en = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      vecs++;
      if (units !== 4'd0 || tens !== 3'd0) begin
         errs++;
         $display("FAIL async_reset got %0d%0d want 00", tens, units);
      end
      en = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_gated_enable();
      logic [3:0] exp_u [4];
      logic [2:0] exp_t [4];
      exp_u = '{4'd9, 4'd9, 4'd0, 4'd0};
      exp_t = '{3'd0, 3'd0, 3'd1, 3'd1};
      clear_now();
      run_en(8);
      vecs++;
      if (units !== 4'd8 || tens !== 3'd0) begin
         errs++;
         $display("FAIL gate_start got %0d%0d want 08", tens, units);
      end
      for (int i = 0; i < 4; i++) begin
         en = (i % 2 == 0);
         step();
         vecs++;
         if (units !== exp_u[i] || tens !== exp_t[i]) begin
            errs++;
            $display("FAIL gate_step %0d got %0d%0d want %0d%0d", i, tens, units, exp_t[i], exp_u[i]);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_clear_priority();
      clear_now();
      run_en(45);
      vecs++;
      if (units !== 4'd5 || tens !== 3'd4) begin
         errs++;
         $display("FAIL clr_start got %0d%0d want 45", tens, units);
      end
      clr = 1'b1;
      ld = 1'b1;
      ld_units = 4'd3;
      ld_tens = 3'd2;
      en = 1'b1;
      step();
      clr = 1'b0;
      ld = 1'b0;
      en = 1'b0;
      vecs++;
      if (units !== 4'd0 || tens !== 3'd0) begin
         errs++;
         $display("FAIL clr_priority got %0d%0d want 00", tens, units);
      end
      run_en(59);
      en = 1'b1;
      clr = 1'b1;
      #1;
      vecs++;
      if (carry_out !== 1'b1) begin
         errs++;
         $display("FAIL clr_at59_carry got %b want 1", carry_out);
      end
      step();
      clr = 1'b0;
      en = 1'b0;
      vecs++;
      if (units !== 4'd0 || tens !== 3'd0) begin
         errs++;
         $display("FAIL clr_at59 got %0d%0d want 00", tens, units);
      end
   endtask

`ifdef BCD60_LOAD_EN
   task automatic test_load();
      clear_now();
      ld = 1'b1;
      ld_units = 4'd8;
      ld_tens = 3'd5;
      step();
      ld = 1'b0;
      vecs++;
      if (units !== 4'd8 || tens !== 3'd5 || tc !== 1'b0) begin
         errs++;
         $display("FAIL load_58 got %0d%0d tc=%b want 58 tc=0", tens, units, tc);
      end
      en = 1'b1;
      step();
      vecs++;
      if (units !== 4'd9 || tens !== 3'd5 || tc !== 1'b1 || carry_out !== 1'b1) begin
         errs++;
         $display("FAIL load_59 got %0d%0d tc=%b co=%b want 59 1 1", tens, units, tc, carry_out);
      end
      step();
      en = 1'b0;
      vecs++;
      if (units !== 4'd0 || tens !== 3'd0) begin
         errs++;
         $display("FAIL load_wrap got %0d%0d want 00", tens, units);
      end
      run_en(4);
      ld = 1'b1;
      ld_units = 4'd11;
      ld_tens = 3'd6;
      step();
      vecs++;
      if (units !== 4'd0 || tens !== 3'd0) begin
         errs++;
         $display("FAIL load_oor got %0d%0d want 00", tens, units);
      end
      ld_units = 4'd12;
      ld_tens = 3'd3;
      step();
      vecs++;
      if (units !== 4'd0 || tens !== 3'd3) begin
         errs++;
         $display("FAIL load_units_oor got %0d%0d want 30", tens, units);
      end
      ld_units = 4'd7;
      ld_tens = 3'd7;
      step();
      vecs++;
      if (units !== 4'd7 || tens !== 3'd0) begin
         errs++;
         $display("FAIL load_tens_oor got %0d%0d want 07", tens, units);
      end
      ld_units = 4'd3;
      ld_tens = 3'd2;
      en = 1'b1;
      step();
      ld = 1'b0;
      en = 1'b0;
      vecs++;
      if (units !== 4'd3 || tens !== 3'd2) begin
         errs++;
         $display("FAIL load_over_en got %0d%0d want 23", tens, units);
      end
   endtask
`endif

   initial begin
      vecs = 0;
      errs = 0;
      rst_n = 1'b0;
      en = 1'b0;
      clr = 1'b0;
      ld = 1'b0;
      ld_units = 4'd0;
      ld_tens = 3'd0;
      #1;
      test_reset();
      test_free_run();
      test_async_reset();
      test_gated_enable();
      test_clear_priority();
`ifdef BCD60_LOAD_EN
      test_load();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
